// File: rtl/tick_div_bank_if.sv
`default_nettype none
// ============================================================================
// Module      : tick_div_bank_if
// Description : Control/status bundle for tick_div_bank. It carries the global
//               run enable, the divisor load handshake (load, load_ch, div_in,
//               oneshot_in, load_ack), the per-channel one-shot triggers
//               (start) and the per-channel outputs (tick, busy).
//               Optional: TICK_DIV_SYNC_EN adds the 'sync' phase-align strobe.
//               master : drives the controls, observes the outputs
//               slave  : the tick bank itself
// Revision    : 1.0 - initial release
// ============================================================================
interface tick_div_bank_if #(
    parameter int WIDTH = 16,
    parameter int NCH   = 4
);
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

    logic             en;
    logic             load;
    logic [CHW-1:0]   load_ch;
    logic [WIDTH-1:0] div_in;
    logic             oneshot_in;
    logic             load_ack;
    logic [NCH-1:0]   start;
    logic [NCH-1:0]   tick;
    logic [NCH-1:0]   busy;
`ifdef TICK_DIV_SYNC_EN
    logic             sync;

    modport master (
        output en, load, load_ch, div_in, oneshot_in, start, sync,
        input  load_ack, tick, busy
    );
    modport slave (
        input  en, load, load_ch, div_in, oneshot_in, start, sync,
        output load_ack, tick, busy
    );
`else
    modport master (
        output en, load, load_ch, div_in, oneshot_in, start,
        input  load_ack, tick, busy
    );
    modport slave (
        input  en, load, load_ch, div_in, oneshot_in, start,
        output load_ack, tick, busy
    );
`endif
endinterface
`default_nettype wire

// File: rtl/tick_div_bank.sv
`default_nettype none
// ============================================================================
// Module      : tick_div_bank
// Description : NCH independent divide-by-D enable-tick channels with
//               WIDTH-bit divisors. Each channel runs continuously or as a
//               one-shot, and its divisor is reloaded through a load
//               handshake. A divisor change on a running channel is held in a
//               shadow register and only takes effect at the channel's next
//               tick, so no short or doubled period is ever produced.
//               Optional: define TICK_DIV_SYNC_EN to add bus.sync, which
//               re-phases every running continuous channel.
// Ports       : clk   - system clock, rising edge
//               rst_n - asynchronous active-low reset
//               bus   - tick_div_bank_if.slave (en, load, load_ch, div_in,
//                       oneshot_in, load_ack, start, tick, busy[, sync])
// Revision    : 1.0 - initial release
// ============================================================================
module tick_div_bank #(
    parameter int WIDTH = 16,
    parameter int NCH   = 4
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    tick_div_bank_if.slave   bus
);
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
    // Channel count widened by one bit so out-of-range selects are visible.
    localparam logic [CHW:0] c_nch = (CHW+1)'(NCH);

    logic w_load_ok;
    logic r_load_ack;

    assign w_load_ok    = bus.load && ({1'b0, bus.load_ch} < c_nch);
    assign bus.load_ack = r_load_ack;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_load_ack <= 1'b0;
        end else begin
            r_load_ack <= w_load_ok;
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [WIDTH-1:0] r_cnt;
        logic [WIDTH-1:0] r_div;
        logic [WIDTH-1:0] r_shd;
        logic             r_pend;
        logic             r_mode;
        logic             r_shm;
        logic             r_run;
        logic             r_tick;

        logic             w_sel;
        logic [WIDTH-1:0] w_dm1;
        logic             w_cnt_en;
        logic             w_wrap;
        logic             w_idle;
        logic             w_sync_hit;
        logic             w_take_new;
        logic             w_take_shd;
        logic [WIDTH-1:0] w_d_nxt;
        logic             w_m_nxt;
        logic             w_start_hit;

        assign w_sel    = w_load_ok && (bus.load_ch == CHW'(i));
        // Only consumed when r_div != 0, so the wrap at D = 0 is harmless.
        assign w_dm1    = r_div - WIDTH'(1);
        assign w_cnt_en = bus.en && (r_div != '0) && (!r_mode || r_run);
        assign w_wrap   = w_cnt_en && (r_cnt == w_dm1);
        assign w_idle   = (r_div == '0) || (r_mode && !r_run);

`ifdef TICK_DIV_SYNC_EN
        assign w_sync_hit = bus.sync && bus.en && !r_mode && (r_div != '0);
`else
        assign w_sync_hit = 1'b0;
`endif

        // A load lands directly when the channel is idle, or when it coincides
        // with a tick so that the tick completes and the new divisor governs
        // the very next period. Otherwise it waits in the shadow registers.
        assign w_take_new = w_sel && (w_idle || w_wrap);
        assign w_take_shd = !w_sel && r_pend && (w_wrap || w_sync_hit);

        // Divisor/mode after this edge: START is evaluated against these so
        // a coincident LOAD is applied first.
        always_comb begin
            w_d_nxt = r_div;
            w_m_nxt = r_mode;
            if (w_take_new) begin
                w_d_nxt = bus.div_in;
                w_m_nxt = bus.oneshot_in;
            end else if (w_take_shd) begin
                w_d_nxt = r_shd;
                w_m_nxt = r_shm;
            end
        end

        assign w_start_hit = bus.start[i] && bus.en && w_m_nxt && (w_d_nxt != '0);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_cnt  <= '0;
                r_div  <= '0;
                r_shd  <= '0;
                r_pend <= 1'b0;
                r_mode <= 1'b0;
                r_shm  <= 1'b0;
                r_run  <= 1'b0;
                r_tick <= 1'b0;
            end else begin
                r_tick <= w_wrap;

                r_div  <= w_d_nxt;
                r_mode <= w_m_nxt;

                if (w_sel && !w_take_new) begin
                    r_shd  <= bus.div_in;
                    r_shm  <= bus.oneshot_in;
                    r_pend <= 1'b1;
                end else if (w_take_new || w_take_shd) begin
                    r_pend <= 1'b0;
                end

                if (w_take_new || w_start_hit || w_sync_hit || w_wrap) begin
                    r_cnt <= '0;
                end else if (w_cnt_en) begin
                    r_cnt <= r_cnt + WIDTH'(1);
                end

                if (w_start_hit) begin
                    r_run <= 1'b1;
                end else if (w_take_new || (w_wrap && r_mode)) begin
                    r_run <= 1'b0;
                end
            end
        end

        assign bus.tick[i] = r_tick;
        assign bus.busy[i] = (r_div != '0) && (!r_mode || r_run);
    end : g_ch

endmodule
`default_nettype wire

// File: tb/tb_tick_div_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_tick_div_bank
// Description : Directed self-checking bench for tick_div_bank (WIDTH=16,
//               NCH=5 so that an out-of-range load_ch is expressible).
//               Optional: TICK_DIV_SYNC_EN enables the sync phase-align case.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tick_div_bank;
    localparam int WIDTH = 16;
    localparam int NCH   = 5;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    tick_div_bank_if #(.WIDTH(WIDTH), .NCH(NCH)) bus ();

    tick_div_bank #(.WIDTH(WIDTH), .NCH(NCH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges and settle 1 ns past the last one.
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.en         = 1'b1;
        bus.load       = 1'b0;
        bus.load_ch    = '0;
        bus.div_in     = '0;
        bus.oneshot_in = 1'b0;
        bus.start      = '0;
`ifdef TICK_DIV_SYNC_EN
        bus.sync       = 1'b0;
`endif
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        cyc(1);
    endtask

    task automatic set_load(input int ch, input int d, input logic os);
        bus.load       = 1'b1;
        bus.load_ch    = 3'(ch);
        bus.div_in     = 16'(d);
        bus.oneshot_in = os;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        idle_inputs();
        rst_n = 1'b0;
        cyc(2);

        // Reset state
        chk("rst_tick", 32'(bus.tick), 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        chk("rst_ack",  32'(bus.load_ack), 32'h0);
        rst_n = 1'b1;
        cyc(1);

        // ch0 D=4 continuous: ack one cycle after load, ticks 4,8 edges later
        set_load(0, 4, 1'b0);
        cyc(1);
        bus.load = 1'b0;
        chk("t1_ack",   32'(bus.load_ack), 32'h1);
        chk("t1_busy0", 32'(bus.busy[0]), 32'h1);
        for (int k = 1; k <= 8; k++) begin
            cyc(1);
            chk($sformatf("t1_tick0 k=%0d", k), 32'(bus.tick[0]), (k % 4 == 0) ? 32'h1 : 32'h0);
            if (k == 1) chk("t1_ack_low", 32'(bus.load_ack), 32'h0);
        end

        // ch1 D=1 always ticking, ch2 D=0 idle
        do_reset();
        set_load(1, 1, 1'b0);
        cyc(1);
        set_load(2, 0, 1'b0);
        cyc(1);
        bus.load = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("t2_tick1 k=%0d", k), 32'(bus.tick[1]), 32'h1);
            chk($sformatf("t2_tick2 k=%0d", k), 32'(bus.tick[2]), 32'h0);
            chk($sformatf("t2_busy2 k=%0d", k), 32'(bus.busy[2]), 32'h0);
            cyc(1);
        end

        // ch0 D=5, reload D=3 mid-period: ticks at 5,10 then 13,16
        do_reset();
        set_load(0, 5, 1'b0);
        cyc(1);
        bus.load = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            if (k == 7) set_load(0, 3, 1'b0);
            cyc(1);
            bus.load = 1'b0;
            if (k == 7) chk("t3_ack", 32'(bus.load_ack), 32'h1);
            chk($sformatf("t3_tick0 k=%0d", k), 32'(bus.tick[0]),
                (k == 5 || k == 10 || k == 13 || k == 16) ? 32'h1 : 32'h0);
        end

        // ch3 one-shot D=6: START at 2, restart at 5, single tick at 11
        do_reset();
        set_load(3, 6, 1'b1);
        cyc(1);
        bus.load = 1'b0;
        chk("t4_busy_idle", 32'(bus.busy[3]), 32'h0);
        for (int k = 1; k <= 14; k++) begin
            if (k == 2 || k == 5) bus.start[3] = 1'b1;
            cyc(1);
            bus.start = '0;
            chk($sformatf("t4_tick3 k=%0d", k), 32'(bus.tick[3]), (k == 11) ? 32'h1 : 32'h0);
            if (k == 3 || k == 10) chk($sformatf("t4_busy k=%0d", k), 32'(bus.busy[3]), 32'h1);
            if (k == 12) chk("t4_busy_drop", 32'(bus.busy[3]), 32'h0);
        end

        // ch0 D=8, EN low 10 cycles at cnt=5: tick 3 edges after EN returns
        do_reset();
        set_load(0, 8, 1'b0);
        cyc(1);
        bus.load = 1'b0;
        for (int k = 1; k <= 18; k++) begin
            if (k == 6)  bus.en = 1'b0;
            if (k == 16) bus.en = 1'b1;
            cyc(1);
            chk($sformatf("t5_tick0 k=%0d", k), 32'(bus.tick[0]), (k == 18) ? 32'h1 : 32'h0);
        end
        chk("t5_busy_run", 32'(bus.busy[0]), 32'h1);
        // Asynchronous reset while the tick is high
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_tick", 32'(bus.tick), 32'h0);
        chk("t5_rst_busy", 32'(bus.busy), 32'h0);
        chk("t5_rst_ack",  32'(bus.load_ack), 32'h0);
        cyc(1);
        rst_n = 1'b1;
        cyc(1);

        // Out-of-range channel select: no ack, no state change
        do_reset();
        set_load(NCH, 3, 1'b0);
        cyc(1);
        bus.load = 1'b0;
        chk("t6_ack", 32'(bus.load_ack), 32'h0);
        chk("t6_busy", 32'(bus.busy), 32'h0);
        cyc(3);
        chk("t6_tick", 32'(bus.tick), 32'h0);

`ifdef TICK_DIV_SYNC_EN
        // ch0 D=4, ch1 D=8 loaded 2 edges apart; SYNC at edge 5 aligns them
        do_reset();
        set_load(0, 4, 1'b0);
        cyc(1);
        bus.load = 1'b0;
        for (int k = 1; k <= 13; k++) begin
            if (k == 2) set_load(1, 8, 1'b0);
            if (k == 5) bus.sync = 1'b1;
            cyc(1);
            bus.load = 1'b0;
            bus.sync = 1'b0;
            chk($sformatf("t7_tick0 k=%0d", k), 32'(bus.tick[0]),
                (k == 4 || k == 9 || k == 13) ? 32'h1 : 32'h0);
            chk($sformatf("t7_tick1 k=%0d", k), 32'(bus.tick[1]), (k == 13) ? 32'h1 : 32'h0);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/tick_div_bank.md
# tick_div_bank

Parametrised multi-channel enable-tick generator: the successor to the single 3-bit clock divider in the PWM increment/decrement path. It provides NCH independent divide-by-N tick channels with WIDTH-bit divisors, runtime reload through a load handshake, and a per-channel one-shot mode. It sits between the system clock and the PWM/stepper logic and drives their single-cycle clock-enable inputs. No derived clocks are generated.

## Interface
- WIDTH, 16: divisor and counter width per channel.
- NCH, 4: number of tick channels (1..16).
- CHW, $clog2(NCH) min 1: width of the channel select field (derived, not overridden).

- CLK  in  1  system clock; all logic is on its rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- EN  in  1  global run; when low, all counters hold and TICK is forced to 0.
- LOAD  in  1  single-cycle strobe that writes DIV_IN/ONESHOT_IN to channel LOAD_CH.
- LOAD_CH  in  CHW  target channel for LOAD.
- DIV_IN  in  WIDTH  new divisor; 0 disables the channel.
- ONESHOT_IN  in  1  new mode: 0 = continuous, 1 = one-shot.
- LOAD_ACK  out  1  pulses for 1 cycle, one cycle after an accepted LOAD.
- START  in  NCH  per-channel one-shot trigger; ignored in continuous mode.
- TICK  out  NCH  per-channel single-cycle enable pulse, registered.
- BUSY  out  NCH  per-channel: continuous and enabled (D≠0), or one-shot with a count in progress.

## Operation
- Each channel has: counter cnt[WIDTH], active divisor D, shadow divisor S, pending flag P, mode M, and running flag R (one-shot only).
- Continuous mode, D≠0, EN=1: if cnt == D-1, then TICK=1 and cnt←0. Otherwise cnt←cnt+1 and TICK=0. D-1 is computed in WIDTH bits and is guarded by D≠0.
- D=1 gives TICK high every cycle. D=N gives exactly one tick per N cycles. The first tick comes N cycles after the channel starts counting.
- D=0: the channel is idle, TICK=0, BUSY=0, and cnt is held at 0.
- One-shot mode: START[i] sets R and clears cnt. The channel counts while EN is high and emits exactly one TICK at cnt == D-1, then clears R. START while R=1 restarts from 0 with no tick. START with D=0 is ignored.
- LOAD acceptance:
  - LOAD is accepted when LOAD_CH < NCH.
  - If LOAD_CH ≥ NCH, LOAD is dropped and LOAD_ACK stays 0.
- Reload rules for an accepted LOAD:
  - If the target channel is idle (D=0, or one-shot with R=0), D, M and cnt←0 update immediately.
  - Otherwise S and M are stored and P is set. D←S and M take effect on the cycle after the channel's next TICK, giving a glitch-free period change.
  - A second LOAD to the same channel while P=1 overwrites S.
- Simultaneous events:
  - LOAD and TICK on the same channel in the same cycle: the tick completes normally, and the new divisor governs the following period.
  - START and LOAD on the same channel in the same cycle: LOAD is applied first, then START uses the new D and M.
- EN low: cnt, R and P are frozen and TICK=0. Counting resumes from the frozen cnt when EN returns high.
- Reset (RST_N=0, asynchronous): TICK=0, BUSY=0 and LOAD_ACK=0 for all channels. All cnt, D, S, P and R are cleared, and M is set to continuous. After reset every channel is disabled until it is loaded.

## Timing
- TICK is registered: one cycle wide, asserted in the cycle after the counter reaches D-1.
- LOAD at edge k gives LOAD_ACK high during cycle k+1. For an idle channel, the first tick comes D cycles after the LOAD edge.
- START at edge k, with EN held high, gives TICK high during cycle k+D.
- BUSY updates at the same edge as the state it reflects.
- No combinational path runs from inputs to outputs.

## Configuration
- TICK_DIV_SYNC_EN defined:
  - Adds input SYNC (1 bit).
  - A SYNC pulse clears cnt to 0 in every enabled continuous channel on the same edge.
  - The same pulse applies every pending S→D, so channels come back phase-aligned.
  - SYNC has priority over a coincident tick (the tick is still emitted that cycle) and is ignored by one-shot channels.
- Not defined: the SYNC port is absent and channels free-run with independent phase.

## Test plan
- Reset then load ch0 with D=4, continuous, EN=1 -> LOAD_ACK one cycle after LOAD; TICK[0] every 4th cycle; first tick 4 cycles after LOAD.
- D=1 on ch1 and D=0 on ch2 -> TICK[1] continuously high, TICK[2] never high, BUSY[2]=0.
- ch0 running at D=5; LOAD D=3 mid-period -> current 5-cycle period completes, then 3-cycle periods; no short or double tick.
- ch3 one-shot with D=6; START, then a second START 3 cycles later -> exactly one TICK, 6 cycles after the second START; BUSY drops the cycle after the tick.
- EN low for 10 cycles mid-count at D=8, cnt=5 -> no ticks while EN is low; tick 3 cycles after EN returns high. RST_N asserted mid-count -> all outputs 0 immediately.
- With TICK_DIV_SYNC_EN: ch0 D=4 and ch1 D=8 at different phases, then a SYNC pulse -> both tick 4 and 8 cycles after SYNC respectively. LOAD_CH=NCH -> no LOAD_ACK and no state change.
